// File: rtl/mem_arb_pkg.sv
// Shared definitions for the two-port memory request arbiter.
package mem_arb_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_ISSUE = 3'd1,
        ST_WAIT  = 3'd2,
        ST_RESP  = 3'd3,
        ST_GAP   = 3'd4
    } arb_state_e;

    localparam logic OWNER_CPU = 1'b0;
    localparam logic OWNER_LDR = 1'b1;

    localparam logic REQ_READ  = 1'b0;
    localparam logic REQ_WRITE = 1'b1;

    localparam int DEF_ADDR_W         = 16;
    localparam int DEF_DATA_W         = 16;
    localparam int DEF_TIMEOUT_CYCLES = 1023;

    // Watchdog counter width; at least one bit so a disabled watchdog still elaborates.
    function automatic int cnt_width(input int timeout);
        return (timeout > 0) ? $clog2(timeout + 1) : 1;
    endfunction

endpackage

// File: rtl/mem_arb_rr2.sv
// Two-input tie-break. Bit 0 of req is the CPU, bit 1 the loader.
// Holds the owner of the most recent grant so ties alternate.
module mem_arb_rr2
    import mem_arb_pkg::*;
#(
    parameter int LDR_PRIORITY = 0
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] req,
    input  logic       update_en,
    output logic       winner
);

    logic last_owner_q;
    logic last_owner_d;

    // Single requester wins outright; a tie goes to the loader or to the port that did not win last.
    always_comb begin
        winner = OWNER_CPU;
        if (req[1] && !req[0]) begin
            winner = OWNER_LDR;
        end else if (req[1] && req[0]) begin
            winner = (LDR_PRIORITY != 0) ? OWNER_LDR : ~last_owner_q;
        end
    end

    // Remember the winner only when a grant is actually taken.
    always_comb begin
        last_owner_d = last_owner_q;
        if (update_en) begin
            last_owner_d = winner;
        end
    end

    // Reset to the loader so that the first tie is handed to the CPU.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            last_owner_q <= OWNER_LDR;
        end else begin
            last_owner_q <= last_owner_d;
        end
    end

endmodule

// File: rtl/mem_request_arbiter.sv
// Shares one memory controller between the CPU and the UART loader.
// One transaction per grant: capture, pulse mem_request, wait for the
// matching completion strobe (or watchdog), strobe done, then one gap cycle.
module mem_request_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W         = DEF_ADDR_W,
    parameter int DATA_W         = DEF_DATA_W,
    parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES,
    parameter int LDR_PRIORITY   = 0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic [DATA_W-1:0] cpu_rdata,
    output logic              cpu_done,
    output logic              cpu_err,
    input  logic              ldr_req,
    input  logic              ldr_we,
    input  logic [ADDR_W-1:0] ldr_addr,
    input  logic [DATA_W-1:0] ldr_wdata,
    output logic [DATA_W-1:0] ldr_rdata,
    output logic              ldr_done,
    output logic              ldr_err,
    output logic              mem_request,
    output logic              mem_request_type,
    output logic [ADDR_W-1:0] mem_request_address,
    output logic [DATA_W-1:0] mem_write_data,
    input  logic [DATA_W-1:0] mem_data_out,
    input  logic              mem_memory_ready,
    input  logic              mem_write_complete,
    output logic              busy,
    output logic              grant_owner,
    output logic [2:0]        dbg_state
);

    localparam int CNT_W = cnt_width(TIMEOUT_CYCLES);
    localparam logic [CNT_W-1:0] TO_LAST = CNT_W'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);

    // Handshake: cpu_req/ldr_req are levels held until the matching done strobe
    // and dropped by the cycle after it; the controller answers a one-cycle
    // mem_request with a one-cycle mem_memory_ready (read) or mem_write_complete
    // (write). Strobes outside WAIT, or of the wrong kind, are ignored.

    arb_state_e        state_q, state_d;
    logic              mem_request_q, mem_request_d;
    logic              mem_type_q, mem_type_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
    logic [DATA_W-1:0] cpu_rdata_q, cpu_rdata_d;
    logic [DATA_W-1:0] ldr_rdata_q, ldr_rdata_d;
    logic              cpu_done_q, cpu_done_d;
    logic              cpu_err_q, cpu_err_d;
    logic              ldr_done_q, ldr_done_d;
    logic              ldr_err_q, ldr_err_d;
    logic              busy_q, busy_d;
    logic              owner_q, owner_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              err_pending_q, err_pending_d;

    logic              arb_en;
    logic              winner;
    logic              complete;
    logic              timed_out;

    mem_arb_rr2 #(
        .LDR_PRIORITY(LDR_PRIORITY)
    ) u_rr2 (
        .clk      (clk),
        .reset    (reset),
        .req      ({ldr_req, cpu_req}),
        .update_en(arb_en),
        .winner   (winner)
    );

    // Next-state and next-output logic for the transaction sequencer.
    always_comb begin
        state_d       = state_q;
        mem_request_d = 1'b0;
        mem_type_d    = mem_type_q;
        mem_addr_d    = mem_addr_q;
        mem_wdata_d   = mem_wdata_q;
        cpu_rdata_d   = cpu_rdata_q;
        ldr_rdata_d   = ldr_rdata_q;
        cpu_done_d    = 1'b0;
        cpu_err_d     = 1'b0;
        ldr_done_d    = 1'b0;
        ldr_err_d     = 1'b0;
        owner_d       = owner_q;
        cnt_d         = cnt_q;
        err_pending_d = err_pending_q;
        arb_en        = 1'b0;
        complete      = (mem_type_q == REQ_WRITE) ? mem_write_complete : mem_memory_ready;
        timed_out     = (TIMEOUT_CYCLES != 0) && (cnt_q == TO_LAST);

        case (state_q)
            ST_IDLE: begin
                if (cpu_req || ldr_req) begin
                    arb_en        = 1'b1;
                    owner_d       = winner;
                    mem_request_d = 1'b1;
                    state_d       = ST_ISSUE;
                    if (winner == OWNER_LDR) begin
                        mem_type_d  = ldr_we;
                        mem_addr_d  = ldr_addr;
                        mem_wdata_d = ldr_wdata;
                    end else begin
                        mem_type_d  = cpu_we;
                        mem_addr_d  = cpu_addr;
                        mem_wdata_d = cpu_wdata;
                    end
                end
            end
            ST_ISSUE: begin
                cnt_d   = '0;
                state_d = ST_WAIT;
            end
            ST_WAIT: begin
                if (TIMEOUT_CYCLES != 0) begin
                    cnt_d = cnt_q + 1'b1;
                end
                if (complete) begin
                    // Completion beats a same-cycle timeout.
                    state_d = ST_RESP;
                    if (owner_q == OWNER_LDR) begin
                        ldr_done_d = 1'b1;
                        if (mem_type_q == REQ_READ) ldr_rdata_d = mem_data_out;
                    end else begin
                        cpu_done_d = 1'b1;
                        if (mem_type_q == REQ_READ) cpu_rdata_d = mem_data_out;
                    end
                end else if (timed_out) begin
                    err_pending_d = 1'b1;
                    state_d       = ST_RESP;
                    if (owner_q == OWNER_LDR) begin
                        ldr_done_d = 1'b1;
                        ldr_err_d  = 1'b1;
                    end else begin
                        cpu_done_d = 1'b1;
                        cpu_err_d  = 1'b1;
                    end
                end
            end
            ST_RESP: begin
                cnt_d         = '0;
                err_pending_d = 1'b0;
                state_d       = ST_GAP;
            end
            ST_GAP: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        busy_d = (state_d != ST_IDLE);
    end

    // All sequencer state and registered outputs; reset aborts any transaction.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= ST_IDLE;
            mem_request_q <= 1'b0;
            mem_type_q    <= REQ_READ;
            mem_addr_q    <= '0;
            mem_wdata_q   <= '0;
            cpu_rdata_q   <= '0;
            ldr_rdata_q   <= '0;
            cpu_done_q    <= 1'b0;
            cpu_err_q     <= 1'b0;
            ldr_done_q    <= 1'b0;
            ldr_err_q     <= 1'b0;
            busy_q        <= 1'b0;
            owner_q       <= OWNER_CPU;
            cnt_q         <= '0;
            err_pending_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            mem_request_q <= mem_request_d;
            mem_type_q    <= mem_type_d;
            mem_addr_q    <= mem_addr_d;
            mem_wdata_q   <= mem_wdata_d;
            cpu_rdata_q   <= cpu_rdata_d;
            ldr_rdata_q   <= ldr_rdata_d;
            cpu_done_q    <= cpu_done_d;
            cpu_err_q     <= cpu_err_d;
            ldr_done_q    <= ldr_done_d;
            ldr_err_q     <= ldr_err_d;
            busy_q        <= busy_d;
            owner_q       <= owner_d;
            cnt_q         <= cnt_d;
            err_pending_q <= err_pending_d;
        end
    end

    assign mem_request         = mem_request_q;
    assign mem_request_type    = mem_type_q;
    assign mem_request_address = mem_addr_q;
    assign mem_write_data      = mem_wdata_q;
    assign cpu_rdata           = cpu_rdata_q;
    assign cpu_done            = cpu_done_q;
    assign cpu_err             = cpu_err_q;
    assign ldr_rdata           = ldr_rdata_q;
    assign ldr_done            = ldr_done_q;
    assign ldr_err             = ldr_err_q;
    assign busy                = busy_q;
    assign grant_owner         = owner_q;
    assign dbg_state           = state_q;

endmodule

// File: tb/tb_mem_request_arbiter.sv
// Bench for mem_request_arbiter. Instance 0: round-robin ties, watchdog 32.
// Instance 1: loader wins ties, watchdog 8.
module tb_mem_request_arbiter;

    localparam int AW = 16;
    localparam int DW = 16;
    localparam int T0 = 32;
    localparam int T1 = 8;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic          cpu_req [2];
    logic          cpu_we  [2];
    logic [AW-1:0] cpu_addr [2];
    logic [DW-1:0] cpu_wdata [2];
    logic [DW-1:0] cpu_rdata [2];
    logic          cpu_done [2];
    logic          cpu_err  [2];
    logic          ldr_req [2];
    logic          ldr_we  [2];
    logic [AW-1:0] ldr_addr [2];
    logic [DW-1:0] ldr_wdata [2];
    logic [DW-1:0] ldr_rdata [2];
    logic          ldr_done [2];
    logic          ldr_err  [2];
    logic          mreq  [2];
    logic          mtype [2];
    logic [AW-1:0] maddr [2];
    logic [DW-1:0] mwdata [2];
    logic [DW-1:0] mdout [2];
    logic          mready [2];
    logic          mwc [2];
    logic          busy [2];
    logic          gown [2];
    logic [2:0]    dbg [2];

    for (genvar g = 0; g < 2; g++) begin : g_dut
        mem_request_arbiter #(
            .ADDR_W        (AW),
            .DATA_W        (DW),
            .TIMEOUT_CYCLES((g == 0) ? T0 : T1),
            .LDR_PRIORITY  (g)
        ) dut (
            .clk                (clk),
            .reset              (rst),
            .cpu_req            (cpu_req[g]),
            .cpu_we             (cpu_we[g]),
            .cpu_addr           (cpu_addr[g]),
            .cpu_wdata          (cpu_wdata[g]),
            .cpu_rdata          (cpu_rdata[g]),
            .cpu_done           (cpu_done[g]),
            .cpu_err            (cpu_err[g]),
            .ldr_req            (ldr_req[g]),
            .ldr_we             (ldr_we[g]),
            .ldr_addr           (ldr_addr[g]),
            .ldr_wdata          (ldr_wdata[g]),
            .ldr_rdata          (ldr_rdata[g]),
            .ldr_done           (ldr_done[g]),
            .ldr_err            (ldr_err[g]),
            .mem_request        (mreq[g]),
            .mem_request_type   (mtype[g]),
            .mem_request_address(maddr[g]),
            .mem_write_data     (mwdata[g]),
            .mem_data_out       (mdout[g]),
            .mem_memory_ready   (mready[g]),
            .mem_write_complete (mwc[g]),
            .busy               (busy[g]),
            .grant_owner        (gown[g]),
            .dbg_state          (dbg[g])
        );
    end

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;

    task automatic chk(input string nm, input int inst, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s[%0d]: got %0h expected %0h (cycle %0d)", nm, inst, act, exp, cyc);
        end
    endtask

    // ---------------- behavioural model ----------------
    // Transaction timeline per instance: grant on edge g, request pulse visible
    // after g, completion sampled on some WAIT edge c >= g+2 (or the watchdog's
    // last WAIT edge), done visible after c, idle again after c+2.
    bit            m_act [2];
    int            m_g [2];
    int            m_c [2];
    bit            m_own [2];
    bit            m_last [2];
    bit            m_we [2];
    logic [AW-1:0] m_addr [2];
    logic [DW-1:0] m_wd [2];
    logic [DW-1:0] m_cr [2];
    logic [DW-1:0] m_lr [2];
    bit            e_req [2];
    bit            e_cd [2];
    bit            e_ce [2];
    bit            e_ld [2];
    bit            e_le [2];

    function automatic int t_of(input int i);
        return (i == 0) ? T0 : T1;
    endfunction

    initial begin
        forever begin
            @(posedge clk or posedge rst);
            if (rst) begin
                for (int i = 0; i < 2; i++) begin
                    m_act[i] = 0; m_g[i] = 0; m_c[i] = -1; m_own[i] = 0; m_last[i] = 1;
                    m_we[i] = 0; m_addr[i] = '0; m_wd[i] = '0; m_cr[i] = '0; m_lr[i] = '0;
                    e_req[i] = 0; e_cd[i] = 0; e_ce[i] = 0; e_ld[i] = 0; e_le[i] = 0;
                end
            end else begin
                cyc = cyc + 1;
                for (int i = 0; i < 2; i++) begin
                    bit w;
                    bit hit;
                    bit to;
                    int j;
                    e_req[i] = 0; e_cd[i] = 0; e_ce[i] = 0; e_ld[i] = 0; e_le[i] = 0;
                    if (!m_act[i]) begin
                        if (cpu_req[i] || ldr_req[i]) begin
                            if (cpu_req[i] && ldr_req[i]) w = (i == 1) ? 1'b1 : !m_last[i];
                            else w = ldr_req[i];
                            m_own[i]  = w;
                            m_last[i] = w;
                            m_we[i]   = w ? ldr_we[i] : cpu_we[i];
                            m_addr[i] = w ? ldr_addr[i] : cpu_addr[i];
                            m_wd[i]   = w ? ldr_wdata[i] : cpu_wdata[i];
                            m_g[i]    = cyc;
                            m_c[i]    = -1;
                            m_act[i]  = 1;
                            e_req[i]  = 1;
                        end
                    end else if (m_c[i] < 0) begin
                        if (cyc >= m_g[i] + 2) begin
                            j   = cyc - m_g[i] - 2;
                            hit = m_we[i] ? mwc[i] : mready[i];
                            to  = (t_of(i) != 0) && (j == t_of(i) - 1);
                            if (hit || to) begin
                                m_c[i] = cyc;
                                if (hit && !m_we[i]) begin
                                    if (m_own[i]) m_lr[i] = mdout[i];
                                    else m_cr[i] = mdout[i];
                                end
                                if (m_own[i]) begin e_ld[i] = 1; e_le[i] = !hit; end
                                else begin e_cd[i] = 1; e_ce[i] = !hit; end
                            end
                        end
                    end else if (cyc == m_c[i] + 2) begin
                        m_act[i] = 0;
                    end
                end
            end
        end
    end

    // ---------------- per-cycle compare ----------------
    initial begin
        forever begin
            @(negedge clk);
            for (int i = 0; i < 2; i++) begin
                chk("mem_request", i, mreq[i], e_req[i]);
                chk("mem_request_type", i, mtype[i], m_we[i]);
                chk("mem_request_address", i, maddr[i], m_addr[i]);
                chk("mem_write_data", i, mwdata[i], m_wd[i]);
                chk("cpu_rdata", i, cpu_rdata[i], m_cr[i]);
                chk("ldr_rdata", i, ldr_rdata[i], m_lr[i]);
                chk("cpu_done", i, cpu_done[i], e_cd[i]);
                chk("cpu_err", i, cpu_err[i], e_ce[i]);
                chk("ldr_done", i, ldr_done[i], e_ld[i]);
                chk("ldr_err", i, ldr_err[i], e_le[i]);
                chk("busy", i, busy[i], m_act[i]);
                chk("grant_owner", i, gown[i], m_own[i]);
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic set_cpu(input int i, input bit rq, input bit we, input logic [AW-1:0] a, input logic [DW-1:0] d);
        cpu_req[i] = rq; cpu_we[i] = we; cpu_addr[i] = a; cpu_wdata[i] = d;
    endtask

    task automatic set_ldr(input int i, input bit rq, input bit we, input logic [AW-1:0] a, input logic [DW-1:0] d);
        ldr_req[i] = rq; ldr_we[i] = we; ldr_addr[i] = a; ldr_wdata[i] = d;
    endtask

    // Acts as the memory controller for one transaction.
    // kind: 0 read-ready after lat, 1 write-complete after lat, 2 no strobe,
    //       3 stray write-complete 2 cycles in, read-ready after lat.
    task automatic serve(input int i, input int lat, input int kind, input logic [DW-1:0] data,
                         output int wait_n, output bit own, output int rq_cyc,
                         output int dn_cyc, output bit err);
        bit got;
        got = 0; wait_n = 0; own = 0; rq_cyc = 0; dn_cyc = 0; err = 0;
        for (int k = 0; k < 60 && !got; k++) begin
            @(negedge clk);
            wait_n = k + 1;
            got = mreq[i];
        end
        if (!got) begin
            n_checks++; n_errors++;
            $display("FAIL req_wait[%0d]: no mem_request within 60 cycles", i);
            return;
        end
        own    = gown[i];
        rq_cyc = cyc;
        for (int k = 1; k <= lat + 1; k++) begin
            @(negedge clk);
            mready[i] = 0; mwc[i] = 0; mdout[i] = 16'hDEAD;
            if (k == lat) begin
                if (kind == 0 || kind == 3) begin mready[i] = 1; mdout[i] = data; end
                else if (kind == 1) mwc[i] = 1;
            end
            if (kind == 3 && k == 2) mwc[i] = 1;
        end
        got = 0;
        for (int k = 0; k < 60; k++) begin
            if (cpu_done[i] || ldr_done[i]) begin got = 1; break; end
            @(negedge clk);
        end
        if (!got) begin
            n_checks++; n_errors++;
            $display("FAIL done_wait[%0d]: no done within 60 cycles", i);
            return;
        end
        dn_cyc = cyc;
        err    = cpu_err[i] | ldr_err[i];
    endtask

    task automatic do_reset();
        rst = 1;
        repeat (2) @(negedge clk);
        rst = 0;
    endtask

    // ---------------- directed tests ----------------
    int  wn;
    bit  own;
    int  rc;
    int  dc;
    bit  er;
    int  rq_hist [3];
    bit  own_hist [3];

    initial begin
        rst = 1;
        for (int i = 0; i < 2; i++) begin
            set_cpu(i, 0, 0, '0, '0);
            set_ldr(i, 0, 0, '0, '0);
            mdout[i] = 16'hDEAD; mready[i] = 0; mwc[i] = 0;
        end
        repeat (3) @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            chk("rst_busy", i, busy[i], 0);
            chk("rst_mem_request", i, mreq[i], 0);
            chk("rst_grant_owner", i, gown[i], 0);
            chk("rst_cpu_rdata", i, cpu_rdata[i], 16'h0000);
            chk("rst_state", i, dbg[i], 3'd0);
        end
        rst = 0;
        @(negedge clk);

        // CPU read, controller answers 6 cycles after the request pulse.
        set_cpu(0, 1, 0, 16'h1234, 16'h0000);
        serve(0, 6, 0, 16'hBEEF, wn, own, rc, dc, er);
        set_cpu(0, 0, 0, 16'h1234, 16'h0000);
        chk("t1_req_latency", 0, wn, 1);
        chk("t1_owner", 0, own, 0);
        chk("t1_done_delay", 0, dc - rc, 7);
        chk("t1_err", 0, er, 0);
        chk("t1_rdata", 0, cpu_rdata[0], 16'hBEEF);
        chk("t1_addr", 0, maddr[0], 16'h1234);
        chk("t1_type", 0, mtype[0], 0);
        repeat (3) @(negedge clk);

        // Loader write, completion 10 cycles after the request pulse.
        set_ldr(0, 1, 1, 16'h7FA0, 16'h0041);
        serve(0, 10, 1, 16'h0000, wn, own, rc, dc, er);
        set_ldr(0, 0, 1, 16'h7FA0, 16'h0041);
        chk("t2_owner", 0, own, 1);
        chk("t2_done_delay", 0, dc - rc, 11);
        chk("t2_err", 0, er, 0);
        chk("t2_wdata", 0, mwdata[0], 16'h0041);
        chk("t2_addr", 0, maddr[0], 16'h7FA0);
        chk("t2_type", 0, mtype[0], 1);
        chk("t2_ldr_rdata", 0, ldr_rdata[0], 16'h0000);
        chk("t2_cpu_rdata_kept", 0, cpu_rdata[0], 16'hBEEF);
        repeat (3) @(negedge clk);

        // Stray write-complete during a read must not finish it.
        set_cpu(0, 1, 0, 16'h0042, 16'h0000);
        serve(0, 5, 3, 16'h5A5A, wn, own, rc, dc, er);
        set_cpu(0, 0, 0, 16'h0042, 16'h0000);
        chk("t3_done_delay", 0, dc - rc, 6);
        chk("t3_rdata", 0, cpu_rdata[0], 16'h5A5A);
        chk("t3_err", 0, er, 0);
        repeat (3) @(negedge clk);

        // Held simultaneous requests after reset: round-robin instance.
        do_reset();
        set_cpu(0, 1, 0, 16'h1000, 16'h0000);
        set_ldr(0, 1, 0, 16'h2000, 16'h0000);
        for (int k = 0; k < 3; k++) begin
            serve(0, 2, 0, 16'hA000 + 16'(k), wn, own, rc, dc, er);
            rq_hist[k] = rc; own_hist[k] = own;
        end
        set_cpu(0, 0, 0, '0, '0);
        set_ldr(0, 0, 0, '0, '0);
        chk("t4_grant0", 0, own_hist[0], 0);
        chk("t4_grant1", 0, own_hist[1], 1);
        chk("t4_grant2", 0, own_hist[2], 0);
        chk("t4_spacing01", 0, (rq_hist[1] - rq_hist[0]) >= 4, 1);
        chk("t4_spacing12", 0, (rq_hist[2] - rq_hist[1]) >= 4, 1);
        repeat (3) @(negedge clk);

        // Same stimulus on the loader-priority instance.
        set_cpu(1, 1, 0, 16'h1000, 16'h0000);
        set_ldr(1, 1, 0, 16'h2000, 16'h0000);
        for (int k = 0; k < 3; k++) begin
            serve(1, 2, 0, 16'hB000 + 16'(k), wn, own, rc, dc, er);
            own_hist[k] = own;
        end
        set_cpu(1, 0, 0, '0, '0);
        set_ldr(1, 0, 0, '0, '0);
        chk("t5_grant0", 1, own_hist[0], 1);
        chk("t5_grant1", 1, own_hist[1], 1);
        chk("t5_grant2", 1, own_hist[2], 1);
        chk("t5_ldr_rdata", 1, ldr_rdata[1], 16'hB002);
        repeat (3) @(negedge clk);

        // Plain read on instance 1 to give cpu_rdata a known value.
        set_cpu(1, 1, 0, 16'h1111, 16'h0000);
        serve(1, 3, 0, 16'hC0DE, wn, own, rc, dc, er);
        set_cpu(1, 0, 0, 16'h1111, 16'h0000);
        chk("t6_done_delay", 1, dc - rc, 4);
        chk("t6_rdata", 1, cpu_rdata[1], 16'hC0DE);
        repeat (3) @(negedge clk);

        // Watchdog of 8: no completion strobe at all.
        set_cpu(1, 1, 0, 16'h2222, 16'h0000);
        serve(1, 0, 2, 16'h0000, wn, own, rc, dc, er);
        set_cpu(1, 0, 0, 16'h2222, 16'h0000);
        chk("t7_owner", 1, own, 0);
        chk("t7_done_delay", 1, dc - rc, 9);
        chk("t7_err", 1, er, 1);
        chk("t7_rdata_kept", 1, cpu_rdata[1], 16'hC0DE);
        @(negedge clk);
        chk("t7_busy_gap", 1, busy[1], 1);
        @(negedge clk);
        chk("t7_busy_idle", 1, busy[1], 0);
        repeat (2) @(negedge clk);

        // Reset while waiting on the controller.
        set_cpu(0, 1, 0, 16'h3333, 16'h0000);
        begin
            bit got;
            got = 0;
            for (int k = 0; k < 20 && !got; k++) begin
                @(negedge clk);
                got = mreq[0];
            end
            chk("t8_req_seen", 0, got, 1);
        end
        repeat (2) @(negedge clk);
        @(posedge clk);
        #2 rst = 1;
        #1;
        chk("t8_busy", 0, busy[0], 0);
        chk("t8_mem_request", 0, mreq[0], 0);
        chk("t8_cpu_rdata", 0, cpu_rdata[0], 16'h0000);
        chk("t8_ldr_rdata", 0, ldr_rdata[0], 16'h0000);
        chk("t8_state", 0, dbg[0], 3'd0);
        set_cpu(0, 0, 0, '0, '0);
        @(negedge clk);
        rst = 0;
        repeat (4) @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
